regfile_wq: RTL and testbench
=============================

REGFILE_WQ -- requirements
Module: regfile_wq

Interface
REQ-001 Parameter: DEPTH, 2, number of entries in the pending-write queue; legal range 1..4.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 wr_valid  input  1  write request present.
REQ-005 wr_ready  output  1  queue can accept a write this cycle.
REQ-006 wr_addr  input  5  destination register index.
REQ-007 wr_data  input  32  destination register value.
REQ-008 commit_hold  input  1  when high, no queue entry is committed this cycle.
REQ-009 rd_addr1  input  5  read port 1 index.
REQ-010 rd_data1  output  32  read port 1 value.
REQ-011 rd_addr2  input  5  read port 2 index.
REQ-012 rd_data2  output  32  read port 2 value.
REQ-013 q_count  output  3  number of valid queue entries, 0..DEPTH.

Function
REQ-014 The block shall hold 32 registers of 32 bits and feed both read ports through 32-to-1 selection on the read address.
REQ-015 Register 0 shall always read 0; writes to it shall never change any read result.
REQ-016 wr_ready shall be 1 exactly when q_count < DEPTH; this is a combinational function of the current count only, with no dependence on a same-cycle commit.
REQ-017 A write is accepted when wr_valid and wr_ready are both high at a rising edge.
REQ-018 An accepted write with wr_addr != 0 shall enqueue at the tail.
REQ-019 An accepted write with wr_addr == 0 shall be dropped and shall not enqueue.
REQ-020 With commit_hold low and q_count > 0, the head entry shall be written into the register array and popped at the rising edge.
REQ-021 Commit shall take exactly one entry per cycle, in FIFO order.
REQ-022 Enqueue and commit in the same cycle shall both occur, leaving q_count unchanged; this holds including at q_count == DEPTH-1.
REQ-023 With wr_valid high and wr_ready low, the write shall not be accepted and no state shall change; the requester holds its data.
REQ-024 Reads shall be combinational, with this priority:
  - address 0: return 0;
  - else the value of the newest valid queue entry whose address matches;
  - else the register array value.
REQ-025 A write presented in cycle N shall not be forwarded in cycle N.
REQ-026 A write accepted at edge N shall be visible on the read ports from cycle N+1 and shall remain visible continuously through and after its commit.
REQ-027 Queue pointers shall wrap modulo DEPTH; no entry shall be lost or duplicated across wrap-around.
REQ-028 Both read ports shall be independent and may address the same register.
REQ-029 Write-to-read latency shall be 1 cycle via forwarding; write-to-array latency shall be at least 1 cycle and grows by 1 for each held or queued-ahead cycle.

Reset
REQ-030 While reset is high at a rising edge:
  - all 32 registers shall clear to 0;
  - q_count shall clear to 0, discarding pending entries;
  - wr_valid and commit_hold shall be ignored.
REQ-031 In the cycle after reset, wr_ready shall be 1 and both read ports shall return 0 for every address.
REQ-032 Reset asserted mid-operation shall discard all uncommitted writes, and they shall never reach the array.

Verification
REQ-033 Basic write: reset, then write r5=0xDEADBEEF with hold low -> rd_data1 at addr 5 = 0xDEADBEEF from the next cycle; q_count 1 then 0.
REQ-034 Queue full: hold high, write r1=0x11 and r2=0x22 -> q_count=2, wr_ready=0; a third write r3=0x33 is not accepted; releasing hold commits r1 then r2 on consecutive edges.
REQ-035 Forward priority: hold high, write r7=0xA then r7=0xB -> rd_data2 at addr 7 = 0xB; after drain the array holds 0xB.
REQ-036 Register zero: write r0=0xFFFFFFFF -> q_count stays 0 and rd_data1 at addr 0 = 0.
REQ-037 Reset mid-operation: hold high, queue r4=0x44, assert reset for one edge -> q_count=0 and rd_data1 at addr 4 = 0 afterwards.
REQ-038 Simultaneous push/pop and wrap: DEPTH=2, hold low, continuous writes r1..r31 of value=index -> q_count never exceeds 1, all reads correct, and pointers wrap at least 10 times.

Source files
------------

// File: rtl/regfile_wq_if.sv
// Bundles the write-request, commit-control and read-port signals of regfile_wq.
// The master side drives requests; the slave side is the register file itself.
interface regfile_wq_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        commit_hold;
  logic [4:0]  rd_addr1;
  logic [31:0] rd_data1;
  logic [4:0]  rd_addr2;
  logic [31:0] rd_data2;
  logic [2:0]  q_count;

  modport master (
    output wr_valid, wr_addr, wr_data, commit_hold, rd_addr1, rd_addr2,
    input  wr_ready, rd_data1, rd_data2, q_count
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, commit_hold, rd_addr1, rd_addr2,
    output wr_ready, rd_data1, rd_data2, q_count
  );
endinterface

// File: rtl/regfile_wq.sv
// 32x32 register file whose writes pass through a small pending-write queue;
// reads forward the newest queued value so a write is visible one cycle after acceptance.
module regfile_wq #(
  parameter int DEPTH = 2
) (
  input logic         clk,
  input logic         reset,
  regfile_wq_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PTR_W-1:0] ptr_t;

  logic [31:0] regs   [32];
  logic [4:0]  q_addr [DEPTH];
  logic [31:0] q_data [DEPTH];
  ptr_t        head;
  ptr_t        tail;
  logic [2:0]  count;
  logic [2:0]  count_next;
  logic        push;
  logic        pop;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : ptr_t'(p + 1'b1);
  endfunction

  // Oldest-to-newest scan so the last match wins; address 0 overrides everything.
  function automatic logic [31:0] read_port(input logic [4:0] a);
    logic [31:0] v;
    ptr_t        idx;
    v = regs[a];
    for (int i = 0; i < DEPTH; i++) begin
      idx = ptr_t'((int'(head) + i) % DEPTH);
      if (i < int'(count) && q_addr[idx] == a) v = q_data[idx];
    end
    if (a == 5'd0) v = '0;
    return v;
  endfunction

  assign bus.wr_ready = (count < 3'(DEPTH));
  assign bus.q_count  = count;

  always_comb begin
    push       = bus.wr_valid && bus.wr_ready && (bus.wr_addr != 5'd0);
    pop        = !bus.commit_hold && (count != 3'd0);
    count_next = count + {2'b00, push} - {2'b00, pop};
  end

  always_comb begin
    bus.rd_data1 = read_port(bus.rd_addr1);
    bus.rd_data2 = read_port(bus.rd_addr2);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array is reset deliberately: every address must read 0 right after reset.
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        regs[q_addr[head]] <= q_data[head];
        head               <= next_ptr(head);
      end
      if (push) tail <= next_ptr(tail);
      count <= count_next;
    end
  end

  // NOTE: queue payload needs no reset; count gates every use, so stale slots are never read.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      q_addr[tail] <= bus.wr_addr;
      q_data[tail] <= bus.wr_data;
    end
  end

endmodule

// File: tb/tb_regfile_wq.sv
// Self-checking bench for regfile_wq: a queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_regfile_wq;
  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } pend_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  regfile_wq_if bus ();

  regfile_wq #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: architectural registers plus a FIFO of pending writes.
  logic [31:0] mregs [32];
  pend_t       mq [$];
  pend_t       m_e;
  bit          model_on = 0;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].addr == a) return mq[i].data;
    return mregs[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      model_on = 1;
    end else if (model_on) begin
      if (bus.wr_valid && mq.size() < DEPTH && bus.wr_addr != 5'd0) begin
        m_e.addr = bus.wr_addr;
        m_e.data = bus.wr_data;
      end else begin
        m_e.addr = 5'd0;
        m_e.data = 32'd0;
      end
      if (!bus.commit_hold && mq.size() > 0) begin
        mregs[mq[0].addr] = mq[0].data;
        mq.pop_front();
      end
      if (m_e.addr != 5'd0) mq.push_back(m_e);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      check("cyc_rd_data1", bus.rd_data1, model_read(bus.rd_addr1));
      check("cyc_rd_data2", bus.rd_data2, model_read(bus.rd_addr2));
      check("cyc_q_count", {29'd0, bus.q_count}, mq.size());
      check("cyc_wr_ready", {31'd0, bus.wr_ready}, {31'd0, mq.size() < DEPTH});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.wr_valid = v;
    bus.wr_addr  = a;
    bus.wr_data  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_write(1'b0, 5'd0, 32'd0);
    bus.commit_hold = 1'b0;
    bus.rd_addr1    = 5'd0;
    bus.rd_addr2    = 5'd0;
    reset           = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Post-reset: ready, empty, every address reads 0.
    @(negedge clk);
    check("rst_q_count", {29'd0, bus.q_count}, 32'd0);
    check("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    for (int a = 0; a < 32; a++) begin
      bus.rd_addr1 = 5'(a);
      bus.rd_addr2 = 5'(31 - a);
      #1;
      check("rst_rd1_zero", bus.rd_data1, 32'd0);
      check("rst_rd2_zero", bus.rd_data2, 32'd0);
    end

    // Basic write r5 = DEADBEEF; no same-cycle forwarding.
    step();
    drive_write(1'b1, 5'd5, 32'hDEADBEEF);
    bus.rd_addr1 = 5'd5;
    @(negedge clk);
    check("basic_no_same_cycle_fwd", bus.rd_data1, 32'd0);
    step();
    drive_write(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("basic_q_count_1", {29'd0, bus.q_count}, 32'd1);
    check("basic_fwd", bus.rd_data1, 32'hDEADBEEF);
    step();
    @(negedge clk);
    check("basic_q_count_0", {29'd0, bus.q_count}, 32'd0);
    check("basic_after_commit", bus.rd_data1, 32'hDEADBEEF);
    check("model_r5", mregs[5], 32'hDEADBEEF);

    // Queue full under hold; third write refused.
    step();
    bus.commit_hold = 1'b1;
    drive_write(1'b1, 5'd1, 32'h11);
    step();
    drive_write(1'b1, 5'd2, 32'h22);
    step();
    drive_write(1'b1, 5'd3, 32'h33);
    bus.rd_addr2 = 5'd3;
    @(negedge clk);
    check("full_q_count", {29'd0, bus.q_count}, 32'd2);
    check("full_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
    step();
    @(negedge clk);
    check("full_still_2", {29'd0, bus.q_count}, 32'd2);
    check("full_r3_not_taken", bus.rd_data2, 32'd0);
    drive_write(1'b0, 5'd0, 32'd0);
    bus.commit_hold = 1'b0;
    bus.rd_addr1 = 5'd1;
    bus.rd_addr2 = 5'd2;
    step();
    @(negedge clk);
    check("drain_q_count_1", {29'd0, bus.q_count}, 32'd1);
    check("model_r1_first", mregs[1], 32'h11);
    check("model_r2_pending", mregs[2], 32'd0);
    check("drain_rd_r2_fwd", bus.rd_data2, 32'h22);
    step();
    @(negedge clk);
    check("drain_q_count_0", {29'd0, bus.q_count}, 32'd0);
    check("model_r2", mregs[2], 32'h22);
    check("model_r3", mregs[3], 32'd0);

    // Forward priority: newest match wins.
    bus.commit_hold = 1'b1;
    drive_write(1'b1, 5'd7, 32'hA);
    step();
    drive_write(1'b1, 5'd7, 32'hB);
    step();
    drive_write(1'b0, 5'd0, 32'd0);
    bus.rd_addr2 = 5'd7;
    @(negedge clk);
    check("fwd_newest", bus.rd_data2, 32'hB);
    bus.commit_hold = 1'b0;
    step();
    @(negedge clk);
    check("fwd_mid_drain", bus.rd_data2, 32'hB);
    step();
    @(negedge clk);
    check("fwd_drained_q", {29'd0, bus.q_count}, 32'd0);
    check("fwd_drained_rd", bus.rd_data2, 32'hB);
    check("model_r7", mregs[7], 32'hB);

    // Register zero write is dropped.
    drive_write(1'b1, 5'd0, 32'hFFFFFFFF);
    bus.rd_addr1 = 5'd0;
    step();
    drive_write(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("r0_q_count", {29'd0, bus.q_count}, 32'd0);
    check("r0_reads_zero", bus.rd_data1, 32'd0);

    // Reset mid-operation discards the queued write.
    bus.commit_hold = 1'b1;
    drive_write(1'b1, 5'd4, 32'h44);
    bus.rd_addr1 = 5'd4;
    step();
    drive_write(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("mid_rst_queued", bus.rd_data1, 32'h44);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_q_count", {29'd0, bus.q_count}, 32'd0);
    check("mid_rst_rd4", bus.rd_data1, 32'd0);
    bus.commit_hold = 1'b0;
    step();
    step();
    @(negedge clk);
    check("mid_rst_never_committed", bus.rd_data1, 32'd0);
    check("model_r4", mregs[4], 32'd0);
    bus.rd_addr2 = 5'd7;
    #1;
    check("mid_rst_r7_cleared", bus.rd_data2, 32'd0);

    // Streaming push/pop through the wrapping queue.
    bus.commit_hold = 1'b0;
    for (int i = 1; i < 32; i++) begin
      drive_write(1'b1, 5'(i), 32'(i));
      bus.rd_addr1 = 5'(i);
      bus.rd_addr2 = 5'(i - 1);
      @(negedge clk);
      check("stream_ready", {31'd0, bus.wr_ready}, 32'd1);
      check("stream_q_le1", {31'd0, bus.q_count <= 3'd1}, 32'd1);
      check("stream_prev_visible", bus.rd_data2, 32'(i - 1));
      step();
    end
    drive_write(1'b0, 5'd0, 32'd0);
    step();
    @(negedge clk);
    check("stream_empty", {29'd0, bus.q_count}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      bus.rd_addr1 = 5'(a);
      bus.rd_addr2 = 5'(a);
      #1;
      check("stream_final_rd1", bus.rd_data1, 32'(a));
      check("stream_final_rd2", bus.rd_data2, 32'(a));
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
